alu_sequencer: RTL
==================

# alu_sequencer

Command-level controller that sits in front of the 32-bit combinational ALU. It accepts one operation at a time over a valid/ready command port and drives the ALU's X/Y/op_code inputs from registered operands. It captures Z and the flags, then presents the result on a valid/ready result port. It also implements a multi-cycle unsigned MUL (low 32 bits) by iterating the ALU's ADD operation under shift-add control, so MUL needs no separate multiplier datapath.

## Interface
- No parameters; the data width is fixed at 32.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_op  in  5  values 0–15 pass through to the ALU op_code; 16 = MUL; 17–31 are illegal.
- cmd_a  in  32  operand A (ALU X / multiplicand).
- cmd_b  in  32  operand B (ALU Y / multiplier).
- res_valid  out  1  result held stable until accepted.
- res_ready  in  1  consumer accepts the result.
- res_data  out  32  result.
- res_overflow  out  1  overflow flag.
- res_zero  out  1  result equals zero.
- res_err  out  1  illegal opcode.
- busy  out  1  state is not IDLE.
- alu_x  out  32  to ALU X.
- alu_y  out  32  to ALU Y.
- alu_op  out  4  to ALU op_code.
- alu_z  in  32  from ALU Z.
- alu_overflow  in  1  from ALU overflow.
- alu_zero  in  1  from ALU zero.

## Operation
- States: IDLE, EXEC, MUL, DONE.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid, register op, A and B into op_r, a_r and b_r.
  - op 0–15 → EXEC.
  - op 16 → MUL, with acc=0, mcand=cmd_a, mplr=cmd_b, ovf=0.
  - op 17–31 → DONE with res_data=0, res_zero=1, res_overflow=0, res_err=1.
- **EXEC**
  - Drive alu_x=a_r, alu_y=b_r, alu_op=op_r[3:0].
  - At the next edge, capture alu_z, alu_overflow and alu_zero into the result registers with res_err=0, then go to DONE.
  - Ops the ALU does not implement (4, 11–15) return whatever the ALU outputs (0). This is not flagged as an error.
- **MUL** (one iteration per cycle)
  - Drive alu_op=5 (ADD), alu_x=acc, alu_y=mcand.
  - If mplr==0: res_data=acc, res_zero=(acc==0), res_overflow=ovf, res_err=0, go to DONE. ALU outputs are ignored this cycle.
  - Else, if mplr[0]=1: acc←alu_z and ovf←ovf|alu_overflow.
  - Then, in every non-terminal cycle: mcand←mcand<<1 (done internally, bits shifted out are lost) and mplr←mplr>>1 (logical shift).
  - The product is modulo 2^32 (unsigned low word).
  - res_overflow for MUL is the sticky OR of the ALU's add-overflow over the accumulating adds. It is not a full-product overflow indicator.
- **DONE**
  - res_valid=1; result registers are frozen.
  - On res_valid&&res_ready → IDLE.
  - A new command cannot be accepted in the same cycle as the result handshake.
- **ALU drive outside EXEC/MUL:** alu_x=0, alu_y=0, alu_op=0.
- **Reset** (asserted at any time, including mid-MUL or mid-DONE)
  - Immediately: state=IDLE; res_valid=0; res_data=0; res_overflow=0; res_zero=0; res_err=0; busy=0; alu_x/alu_y/alu_op=0; internal acc, mcand, mplr, ovf cleared.
  - cmd_ready=0 while rst_n=0, and 1 from the first cycle after release.
  - Any in-flight result is discarded.

## Timing
- Command handshake at edge E0 (cmd_valid&&cmd_ready).
- **ALU op:** EXEC during cycle E0→E1; res_valid high from E1. Latency is 1 cycle.
- **Illegal op:** res_valid high from E1.
- **MUL:** the cycle count in MUL is k+1, where k = index of the highest set bit of cmd_b plus 1 (k=0 for cmd_b=0). res_valid rises at E0+k+1. The worst case is 33 cycles.
- **Result handshake:** if res_valid&&res_ready at edge Ed, res_valid falls after Ed and cmd_ready rises after Ed. The minimum command-to-command spacing is 3 cycles for an ALU op.
- **Back-pressure:** res_valid, once high, stays high with res_* unchanged until accepted.
- cmd_ready, busy and the ALU drive outputs are decoded from state and registers only. They have no combinational path from cmd_valid or res_ready.
- All flops reset asynchronously on rst_n low and update on the rising edge of clk.

## Test plan
- **ADD:** op=5, A=7, B=5 → res_valid one cycle after accept; res_data=12, res_zero=0, res_err=0, res_overflow=0.
- **SUB flags:** op=6, A=B=0x0000_0005 → res_data=0, res_zero=1.
  - Then op=5, A=0x7FFF_FFFF, B=1 → res_data=0x8000_0000, res_overflow=1.
- **MUL:**
  - A=6, B=7 → 4 MUL cycles, res_valid at E0+4, res_data=42.
  - A=0x1234_5678, B=0 → res_valid at E0+1, res_data=0, res_zero=1.
  - A=B=0xFFFF_FFFF → res_valid at E0+33, res_data=0x0000_0001.
- **Illegal and back-pressure:**
  - op=20 → res_err=1, res_data=0.
  - Hold res_ready=0 for 10 cycles: res_valid and all res_* stay constant and cmd_ready stays 0. Raise res_ready: IDLE follows, and a new command is accepted one cycle later.
- **Reset mid-MUL:** start A=3, B=0x8000_0000 and drop rst_n after 5 cycles.
  - All outputs go to 0 immediately.
  - After release, cmd_ready=1 and op=0 with A=0xF0, B=0x3C returns 0x30 with no residue from the aborted MUL.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-level controller in front of a 32-bit combinational ALU.
// It runs single-cycle ALU ops, and it runs unsigned MUL (low word) as repeated ALU ADDs under shift-add control.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_overflow,
  output logic        res_zero,
  output logic        res_err,
  output logic        busy,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_z,
  input  logic        alu_overflow,
  input  logic        alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  localparam logic [4:0] OP_MUL = 5'd16;
  localparam logic [3:0] OP_ADD = 4'd5;

  state_t      state, state_nx;
  logic [3:0]  op_r;
  logic [31:0] a_r, b_r;
  logic [31:0] acc, mcand, mplr;
  logic        ovf;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (cmd_valid) begin
        if (cmd_op < OP_MUL)       state_nx = EXEC;
        else if (cmd_op == OP_MUL) state_nx = MUL;
        else                       state_nx = DONE;
      end
      EXEC: state_nx = DONE;
      MUL:  if (mplr == '0) state_nx = DONE;
      DONE: if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state and registers only
  always_comb begin
    cmd_ready = (state == IDLE) && rst_n;
    busy      = (state != IDLE);
    res_valid = (state == DONE);
    alu_x     = '0;
    alu_y     = '0;
    alu_op    = '0;
    case (state)
      EXEC: begin
        alu_x  = a_r;
        alu_y  = b_r;
        alu_op = op_r;
      end
      MUL: begin
        alu_x  = acc;
        alu_y  = mcand;
        alu_op = OP_ADD;
      end
      default: ;
    endcase
  end

  // Operand capture, shift-add iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r         <= '0;
      a_r          <= '0;
      b_r          <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplr         <= '0;
      ovf          <= 1'b0;
      res_data     <= '0;
      res_overflow <= 1'b0;
      res_zero     <= 1'b0;
      res_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          op_r <= cmd_op[3:0];
          a_r  <= cmd_a;
          b_r  <= cmd_b;
          if (cmd_op == OP_MUL) begin
            acc   <= '0;
            mcand <= cmd_a;
            mplr  <= cmd_b;
            ovf   <= 1'b0;
          end else if (cmd_op > OP_MUL) begin
            res_data     <= '0;
            res_zero     <= 1'b1;
            res_overflow <= 1'b0;
            res_err      <= 1'b1;
          end
        end
        EXEC: begin
          res_data     <= alu_z;
          res_overflow <= alu_overflow;
          res_zero     <= alu_zero;
          res_err      <= 1'b0;
        end
        MUL: begin
          if (mplr == '0) begin
            res_data     <= acc;
            res_zero     <= (acc == '0);
            res_overflow <= ovf;
            res_err      <= 1'b0;
          end else begin
            if (mplr[0]) begin
              acc <= alu_z;
              ovf <= ovf | alu_overflow;
            end
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
